// File: rtl/ex_muldiv_seq.sv
// Sequential multiply/divide unit for the EX stage.
// MULT/MULTU use one shift-add step per cycle. DIV/DIVU use one restoring
// shift-subtract step per cycle. Each operation runs for BUS_SIZE steps.
// The sign of the result is fixed up on the edge that enters DONE.
//
// Handshake with the pipeline:
//   - EX raises i_start while it holds a mul/div instruction.
//   - o_stall holds IF/ID/EX frozen until the result is ready. It is high
//     in IDLE while i_start is high, and during every RUN cycle.
//   - o_stall drops in the single DONE cycle. That cycle also pulses
//     o_done, so the instruction leaves EX with HI/LO already updated.
//   - i_flush abandons the operation and drops o_stall in the same cycle.
//   - i_reset has priority over i_flush and i_start.
module ex_muldiv_seq #(
   parameter int BUS_SIZE  = 32,
   parameter int CNT_WIDTH = 6
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [1:0]          i_op,
   input  logic [BUS_SIZE-1:0] i_data_A,
   input  logic [BUS_SIZE-1:0] i_data_B,
   input  logic                i_flush,
   output logic                o_stall,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_div_by_zero,
   output logic [BUS_SIZE-1:0] o_hi,
   output logic [BUS_SIZE-1:0] o_lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_is_div;
   logic                  r_neg_q;    // negate product / quotient
   logic                  r_neg_r;    // negate remainder (dividend sign)
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [BUS_SIZE-1:0]   r_acc_hi;   // partial product high / partial remainder
   logic [BUS_SIZE-1:0]   r_acc_lo;   // multiplier shifting out / dividend->quotient
   logic [BUS_SIZE-1:0]   r_b;        // |multiplicand| or |divisor|

   // Operand decode for the start cycle
   logic                  w_op_div;
   logic                  w_op_signed;
   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [BUS_SIZE-1:0]   w_a_mag;
   logic [BUS_SIZE-1:0]   w_b_mag;
   logic                  w_b_zero;
   logic                  w_last;

   // Datapath for one iteration step and the final sign fix-up
   logic [BUS_SIZE:0]     w_sum;
   logic [BUS_SIZE:0]     w_shift;
   logic [BUS_SIZE:0]     w_diff;
   logic [BUS_SIZE-1:0]   w_step_hi;
   logic [BUS_SIZE-1:0]   w_step_lo;
   logic [2*BUS_SIZE-1:0] w_prod;
   logic [2*BUS_SIZE-1:0] w_prod_s;
   logic [BUS_SIZE-1:0]   w_quo;
   logic [BUS_SIZE-1:0]   w_rem;
   logic [BUS_SIZE-1:0]   w_res_hi;
   logic [BUS_SIZE-1:0]   w_res_lo;

   assign w_op_div    = i_op[1];
   assign w_op_signed = ~i_op[0];
   assign w_a_neg     = w_op_signed & i_data_A[BUS_SIZE-1];
   assign w_b_neg     = w_op_signed & i_data_B[BUS_SIZE-1];
   assign w_a_mag     = w_a_neg ? (~i_data_A + 1'b1) : i_data_A;
   assign w_b_mag     = w_b_neg ? (~i_data_B + 1'b1) : i_data_B;
   assign w_b_zero    = (i_data_B == '0);
   assign w_last      = (r_cnt == CNT_WIDTH'(BUS_SIZE - 1));

   // One multiply or divide step, and the sign-corrected result of that step
   always_comb begin
      w_sum     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
      w_shift   = {r_acc_hi, r_acc_lo[BUS_SIZE-1]};
      w_diff    = w_shift - {1'b0, r_b};
      w_step_hi = '0;
      w_step_lo = '0;
      if (r_is_div) begin
         if (!w_diff[BUS_SIZE]) begin
            w_step_hi = w_diff[BUS_SIZE-1:0];
            w_step_lo = {r_acc_lo[BUS_SIZE-2:0], 1'b1};
         end else begin
            w_step_hi = w_shift[BUS_SIZE-1:0];
            w_step_lo = {r_acc_lo[BUS_SIZE-2:0], 1'b0};
         end
      end else begin
         w_step_hi = w_sum[BUS_SIZE:1];
         w_step_lo = {w_sum[0], r_acc_lo[BUS_SIZE-1:1]};
      end
      w_prod   = {w_step_hi, w_step_lo};
      w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
      w_quo    = r_neg_q ? (~w_step_lo + 1'b1) : w_step_lo;
      w_rem    = r_neg_r ? (~w_step_hi + 1'b1) : w_step_hi;
      w_res_hi = r_is_div ? w_rem : w_prod_s[2*BUS_SIZE-1:BUS_SIZE];
      w_res_lo = r_is_div ? w_quo : w_prod_s[BUS_SIZE-1:0];
   end

   // Stall request: starting in IDLE or iterating in RUN, never under flush/reset
   always_comb begin
      o_stall = 1'b0;
      if (!i_reset && !i_flush) begin
         o_stall = ((r_state == S_IDLE) && i_start) || (r_state == S_RUN);
      end
   end

   // Control FSM with registered status outputs, iteration registers and HI/LO
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_is_div      <= 1'b0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_cnt         <= '0;
         r_acc_hi      <= '0;
         r_acc_lo      <= '0;
         r_b           <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_div_by_zero <= 1'b0;
         o_hi          <= '0;
         o_lo          <= '0;
      end else if (i_flush) begin
         r_state       <= S_IDLE;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (w_op_div && w_b_zero) begin
                     // Divide by zero skips iteration entirely
                     r_state       <= S_DONE;
                     o_done        <= 1'b1;
                     o_div_by_zero <= 1'b1;
                     o_hi          <= i_data_A;
                     o_lo          <= '1;
                  end else begin
                     r_state  <= S_RUN;
                     o_busy   <= 1'b1;
                     r_is_div <= w_op_div;
                     r_neg_q  <= w_a_neg ^ w_b_neg;
                     r_neg_r  <= w_a_neg;
                     r_cnt    <= '0;
                     r_acc_hi <= '0;
                     r_acc_lo <= w_op_div ? w_a_mag : w_b_mag;
                     r_b      <= w_op_div ? w_b_mag : w_a_mag;
                  end
               end
            end
            S_RUN: begin
               r_acc_hi <= w_step_hi;
               r_acc_lo <= w_step_lo;
               r_cnt    <= r_cnt + CNT_WIDTH'(1);
               if (w_last) begin
                  r_state <= S_DONE;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  o_hi    <= w_res_hi;
                  o_lo    <= w_res_lo;
               end
            end
            S_DONE: begin
               r_state       <= S_IDLE;
               o_done        <= 1'b0;
               o_div_by_zero <= 1'b0;
            end
            default: begin
               r_state       <= S_IDLE;
               o_busy        <= 1'b0;
               o_done        <= 1'b0;
               o_div_by_zero <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq.
// Stimulus drives operations, and each accepted operation pushes its
// expected HI/LO, divide-by-zero flag and completion cycle. A monitor pops
// one expectation for every o_done pulse and compares it.
module tb_ex_muldiv_seq;
   localparam int W = 32;

   logic         i_clk = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_start = 1'b0;
   logic [1:0]   i_op = 2'b00;
   logic [W-1:0] i_data_A = '0;
   logic [W-1:0] i_data_B = '0;
   logic         i_flush = 1'b0;
   logic         o_stall, o_busy, o_done, o_div_by_zero;
   logic [W-1:0] o_hi, o_lo;

   int cyc = 0;
   int checks = 0;
   int passes = 0;

   logic [W-1:0] exp_hi_q[$];
   logic [W-1:0] exp_lo_q[$];
   logic         exp_dbz_q[$];
   int           exp_cyc_q[$];
   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;

   ex_muldiv_seq #(.BUS_SIZE(W), .CNT_WIDTH(6)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
      .i_data_A(i_data_A), .i_data_B(i_data_B), .i_flush(i_flush),
      .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done),
      .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo)
   );

   // Clock and cycle counter
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: {div_by_zero, HI, LO} from plain arithmetic on the operands
   function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      logic [63:0] t, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin t = sa * sb; return {1'b0, t}; end
         2'b01: begin t = {32'd0, a} * {32'd0, b}; return {1'b0, t}; end
         2'b10: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   // Monitor: every completion pulse must match the oldest expectation
   always @(negedge i_clk) begin
      if (o_done) begin
         if (exp_hi_q.size() == 0) begin
            check_eq("unexpected_done", 64'(o_done), 64'd0);
         end else begin
            check_eq("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
            check_eq("hi", 64'(o_hi), 64'(exp_hi_q.pop_front()));
            check_eq("lo", 64'(o_lo), 64'(exp_lo_q.pop_front()));
            check_eq("div_by_zero", 64'(o_div_by_zero), 64'(exp_dbz_q.pop_front()));
         end
      end else if (o_div_by_zero) begin
         check_eq("dbz_without_done", 64'(o_div_by_zero), 64'd0);
      end
   end

   // Issue one operation and follow it until its DONE cycle
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
      logic [64:0] m;
      int n, lat;
      m = model(op, a, b);
      lat = (op[1] && b == 0) ? 1 : W + 1;
      @(posedge i_clk); #1;
      i_start = 1'b1; i_op = op; i_data_A = a; i_data_B = b;
      n = cyc;
      exp_hi_q.push_back(m[63:32]);
      exp_lo_q.push_back(m[31:0]);
      exp_dbz_q.push_back(m[64]);
      exp_cyc_q.push_back(n + lat);
      last_hi = m[63:32];
      last_lo = m[31:0];
      #1 check_eq("stall_on_start", 64'(o_stall), 64'd1);
      for (int k = 1; k <= lat; k++) begin
         @(posedge i_clk); #1;
         if (noise && k < lat) begin
            i_start  = 1'($urandom_range(0, 1));
            i_op     = 2'($urandom_range(0, 3));
            i_data_A = $urandom;
            i_data_B = $urandom;
         end else begin
            i_start = 1'b0;
         end
         #1;
         if (k < lat) begin
            check_eq("stall_run", 64'(o_stall), 64'd1);
            check_eq("busy_run", 64'(o_busy), 64'd1);
         end else begin
            check_eq("stall_done", 64'(o_stall), 64'd0);
            check_eq("busy_done", 64'(o_busy), 64'd0);
         end
      end
      i_start = 1'b0;
   endtask

   // Start an operation that will be aborted, run it k_stop RUN cycles
   task automatic start_abortable(input logic [1:0] op, input int k_stop);
      @(posedge i_clk); #1;
      i_start = 1'b1; i_op = op; i_data_A = $urandom; i_data_B = $urandom | 32'h1;
      for (int k = 1; k < k_stop; k++) begin
         @(posedge i_clk); #1;
         i_start = 1'b1;            // ignored while RUN
         i_data_A = $urandom;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   initial begin
      bit seen;
      logic [1:0] rop;
      logic [W-1:0] rb;

      // Reset
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b0;
      #1;
      check_eq("reset_hi", 64'(o_hi), 64'd0);
      check_eq("reset_lo", 64'(o_lo), 64'd0);
      check_eq("reset_stall", 64'(o_stall), 64'd0);
      check_eq("reset_busy", 64'(o_busy), 64'd0);
      check_eq("reset_done", 64'(o_done), 64'd0);

      // Directed operations
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'b11, 32'd100, 32'd7, 1'b0);
      run_op(2'b11, 32'd100, 32'd0, 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

      // Randomized operations, with occasional zero divisor
      for (int i = 0; i < 20; i++) begin
         rop = 2'($urandom_range(0, 3));
         rb  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
         run_op(rop, $urandom, rb, 1'($urandom_range(0, 1)));
      end

      // Flush at RUN cycle 10: back to IDLE, HI/LO untouched, no completion
      start_abortable(2'b00, 10);
      i_flush = 1'b1;
      #1 check_eq("flush_stall", 64'(o_stall), 64'd0);
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      #1;
      check_eq("flush_busy", 64'(o_busy), 64'd0);
      check_eq("flush_idle_stall", 64'(o_stall), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_done) seen = 1'b1;
      end
      check_eq("flush_no_done", 64'(seen), 64'd0);
      check_eq("flush_hi_kept", 64'(o_hi), 64'(last_hi));
      check_eq("flush_lo_kept", 64'(o_lo), 64'(last_lo));

      // Flush wins over a simultaneous start
      @(posedge i_clk); #1;
      i_start = 1'b1; i_flush = 1'b1; i_op = 2'b01;
      #1 check_eq("flush_start_stall", 64'(o_stall), 64'd0);
      @(posedge i_clk); #1;
      i_start = 1'b0; i_flush = 1'b0;
      #1 check_eq("flush_start_busy", 64'(o_busy), 64'd0);

      // Reset at RUN cycle 20, then a small multiply
      start_abortable(2'b01, 20);
      i_reset = 1'b1;
      #1 check_eq("reset_run_stall", 64'(o_stall), 64'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      #1;
      check_eq("rst_run_hi", 64'(o_hi), 64'd0);
      check_eq("rst_run_lo", 64'(o_lo), 64'd0);
      check_eq("rst_run_stall", 64'(o_stall), 64'd0);
      check_eq("rst_run_busy", 64'(o_busy), 64'd0);
      check_eq("rst_run_done", 64'(o_done), 64'd0);
      check_eq("rst_run_dbz", 64'(o_div_by_zero), 64'd0);
      run_op(2'b00, 32'd2, 32'd3, 1'b0);

      repeat (4) @(posedge i_clk);
      #1 check_eq("pending_expectations", 64'(exp_hi_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_seq.md
EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 32, operand/result width.
REQ-002 SHALL have parameter CNT_WIDTH, default 6, iteration counter width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_clk  input  1  rising-edge clock.
REQ-005 SHALL have port i_reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_start  input  1  EX holds a mul/div instruction.
REQ-007 SHALL have port i_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 SHALL have port i_data_A  input  BUS_SIZE  forwarded operand A (rs; multiplicand/dividend).
REQ-009 SHALL have port i_data_B  input  BUS_SIZE  forwarded operand B (rt; multiplier/divisor).
REQ-010 SHALL have port i_flush  input  1  abort the operation in progress.
REQ-011 SHALL have port o_stall  output  1  freeze IF/ID/EX this cycle.
REQ-012 SHALL have port o_busy  output  1  RUN state active.
REQ-013 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port o_div_by_zero  output  1  one-cycle pulse, divide with B=0.
REQ-015 SHALL have port o_hi  output  BUS_SIZE  HI register.
REQ-016 SHALL have port o_lo  output  BUS_SIZE  LO register.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-018 SHALL, in IDLE with i_start=1 and i_flush=0, latch i_op, |A|, |B| (magnitudes for signed ops) and the result signs, clear the counter, and enter RUN.
REQ-019 SHALL drive o_stall=1 combinationally in IDLE while i_start=1, and during every RUN cycle; o_stall=0 in DONE so the instruction leaves EX.
REQ-020 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, for exactly BUS_SIZE cycles, then enter DONE.
REQ-021 SHALL, on the DONE-entry edge, write HI/LO: multiply HI:LO = 2*BUS_SIZE-bit product; divide LO = quotient, HI = remainder.
REQ-022 SHALL apply signs after iteration: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-023 SHALL give fixed latency: start accepted at cycle N; o_done=1 and new o_hi/o_lo visible in cycle N+BUS_SIZE+1; DONE returns to IDLE next cycle.
REQ-024 SHALL, for DIV/DIVU with B=0, skip RUN, go IDLE->DONE, set LO=all ones and HI=A, and pulse o_div_by_zero with o_done in cycle N+1.
REQ-025 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, produce LO=0x80000000, HI=0 (no trap).
REQ-026 SHALL ignore i_start in RUN and DONE; a new operation is accepted only in IDLE.
REQ-027 SHALL, on i_flush=1 in any state, go to IDLE next cycle with HI/LO unchanged, no o_done, and o_stall=0 that cycle; flush wins over a simultaneous start.
REQ-028 SHALL change o_hi/o_lo only on the DONE-entry edge or on reset.
REQ-029 SHALL drive o_busy=1 exactly in RUN; o_done and o_div_by_zero only in DONE.

Reset
REQ-030 SHALL, on i_reset=1 at a clock edge, force IDLE, clear the counter, clear o_hi/o_lo to 0, and deassert o_stall, o_busy, o_done and o_div_by_zero, including mid-RUN.
REQ-031 SHALL give reset priority over i_flush and i_start.

Verification
REQ-032 SHALL test MULT A=0xFFFFFFFD (-3), B=7 -> o_done at N+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_stall high N..N+32.
REQ-033 SHALL test MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 SHALL test DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-035 SHALL test DIVU A=100, B=0 -> o_done and o_div_by_zero at N+1, LO=0xFFFFFFFF, HI=100.
REQ-036 SHALL test i_flush at RUN cycle 10 -> IDLE next cycle, HI/LO keep prior values, no o_done; i_start in RUN is ignored.
REQ-037 SHALL test i_reset at RUN cycle 20 -> next cycle IDLE, HI=LO=0, all outputs low; a following MULT 2*3 gives LO=6 at N+33.
